// File: rtl/uart_pkg.sv
// Shared UART definitions: read-side FSM encoding and default word width.
package uart_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_HOLD = 1'b1
  } rd_state_t;

  localparam int DB_DEFAULT = 8;

endpackage

// File: rtl/fifo_receiver_rise_detect.sv
// Registered rising-edge detector with synchronous active-high reset.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Clearing d_q on reset makes a level held across reset look like a new edge.
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/fifo_receiver.sv
// Receive-side UART FIFO, first-word-fall-through, one pop per rising edge of rd.
// Optional sticky overrun flag is built when FIFO_RX_OVERRUN_EN is defined.
module fifo_receiver
  import uart_pkg::*;
#(
  parameter int DB = DB_DEFAULT,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DB-1:0] d_out,
  input  logic          rx_done,
  input  logic          rd,
  output logic [DB-1:0] r_data,
  output logic          rx_empty,
  output logic          rx_full,
  output logic          overrun
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DB-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  rd_state_t     state_q;
  logic          pushEvt, popEvt, pushTake, popTake;

  rise_detect u_rx_rise (.clk(clk), .reset(reset), .d(rx_done), .rise(pushEvt));
  rise_detect u_rd_rise (.clk(clk), .reset(reset), .d(rd),      .rise(popEvt));

  assign rx_empty = (count_q == '0);
  assign rx_full  = (count_q == FULL_CNT);
  assign r_data   = rx_empty ? '0 : mem_q[rptr_q];

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign popTake  = popEvt && (state_q == RD_IDLE) && !rx_empty;
  assign pushTake = pushEvt && (!rx_full || popTake);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (pushTake) wptr_d = wptr_q + 1'b1;
    if (popTake)  rptr_d = rptr_q + 1'b1;
    if (pushTake && !popTake)      count_d = count_q + 1'b1;
    else if (popTake && !pushTake) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RD_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      case (state_q)
        RD_IDLE: if (popEvt) state_q <= RD_HOLD;
        RD_HOLD: if (!rd)    state_q <= RD_IDLE;
        default:             state_q <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pushTake) mem_q[wptr_q] <= d_out;
  end

`ifdef FIFO_RX_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (reset)                            overrun_q <= 1'b0;
    else if (popTake)                     overrun_q <= 1'b0;
    else if (pushEvt && rx_full)          overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_receiver.sv
// Self-checking bench for fifo_receiver: directed scenarios plus random traffic against a queue model.
module tb_fifo_receiver;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, rx_done, rd;
  logic [7:0] d_out, r_data;
  logic       rx_empty, rx_full, overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       prevRx = 1'b0;
  logic       prevRd = 1'b0;
  logic       expOvr = 1'b0;

  fifo_receiver #(.DB(8), .AW(2)) dut (
    .clk(clk), .reset(reset), .d_out(d_out), .rx_done(rx_done), .rd(rd),
    .r_data(r_data), .rx_empty(rx_empty), .rx_full(rx_full), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Queue model: each rising edge of rx_done is one push, each rising edge of rd is one pop.
  task automatic modelStep(input logic rst, input logic rx, input logic rdv, input logic [7:0] d);
    logic push, pop;
    if (rst) begin
      q.delete();
      prevRx = 1'b0;
      prevRd = 1'b0;
      expOvr = 1'b0;
    end else begin
      push = rx && !prevRx;
      pop  = rdv && !prevRd;
      prevRx = rx;
      prevRd = rdv;
      if (pop && q.size() > 0) begin
        void'(q.pop_front());
        expOvr = 1'b0;
      end
      if (push) begin
        if (q.size() < DEPTH) q.push_back(d);
        else expOvr = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rx, input logic rdv, input logic [7:0] d);
    logic [7:0] expData;
    logic       expOvrOut;
    reset = rst; rx_done = rx; rd = rdv; d_out = d;
    @(posedge clk);
    modelStep(rst, rx, rdv, d);
    #1;
    expData = (q.size() > 0) ? q[0] : 8'h00;
`ifdef FIFO_RX_OVERRUN_EN
    expOvrOut = expOvr;
`else
    expOvrOut = 1'b0;
`endif
    checkOutput("r_data",   32'(r_data),   32'(expData));
    checkOutput("rx_empty", 32'(rx_empty), 32'(q.size() == 0));
    checkOutput("rx_full",  32'(rx_full),  32'(q.size() == DEPTH));
    checkOutput("overrun",  32'(overrun),  32'(expOvrOut));
  endtask

  task automatic pushWord(input logic [7:0] v);
    applyStimulus(1'b0, 1'b1, 1'b0, v);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic readWord();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; rx_done = 1'b0; rd = 1'b0; d_out = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    readWord();

    pushWord(8'h11); pushWord(8'h22); pushWord(8'h33); pushWord(8'h44);
    pushWord(8'h55);
    for (int i = 0; i < 4; i++) readWord();

    pushWord(8'h11); pushWord(8'h22); pushWord(8'h33); pushWord(8'h44);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h66);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) readWord();

    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    readWord();

    pushWord(8'h01); pushWord(8'h02); pushWord(8'h03);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    pushWord(8'h99);
    readWord();

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0),
                    8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
